// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: op-select encodings and default width.
package alu_pkg;

  localparam logic SEL_ADD   = 1'b0;
  localparam logic SEL_SUB   = 1'b1;
  localparam int   ALU_WIDTH = 8;

endpackage : alu_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; the ripple chain in process_unit is built from these.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder_bit

// File: rtl/process_unit.sv
// Registered add/subtract slice: r = a + (b ^ sel) + cin, ripple carry, one-cycle latency.
// No handshake: a new operation is accepted every cycle; outputs reflect the previous cycle's inputs.
module process_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             cin,
  output logic [WIDTH-1:0] r,
  output logic             cout
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

  // Subtract inverts b; cin=1 then supplies the +1 of the two's complement.
  assign bb   = (sel == SEL_SUB) ? ~b : b;
  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_fa (
      .a    (a[i]),
      .b    (bb[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r    <= '0;
      cout <= 1'b0;
    end else begin
      r    <= s;
      cout <= c[WIDTH];
    end
  end

endmodule : process_unit

// File: tb/tb_process_unit.sv
// Scoreboard bench for process_unit at WIDTH=1 and WIDTH=8, driven with directed vectors.
module tb_process_unit;
  import alu_pkg::*;

  localparam int W8 = ALU_WIDTH;

  logic          clk;
  logic          rst1, rst8;
  logic          a1, b1, sel1, cin1;
  logic          r1, cout1;
  logic [W8-1:0] a8, b8;
  logic          sel8, cin8;
  logic [W8-1:0] r8;
  logic          cout8;

  logic [1:0]    exp1_q[$];
  logic [W8:0]   exp8_q[$];

  int checks = 0;
  int errors = 0;

  process_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .sel(sel1), .cin(cin1),
    .r(r1), .cout(cout1)
  );

  process_unit #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .sel(sel8), .cin(cin8),
    .r(r8), .cout(cout8)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: set inputs on the falling edge and queue the expected {cout, r}.
  task automatic op1(input logic rs, input logic a, input logic b, input logic sel,
                     input logic cin, input logic er, input logic ec);
    rst1 = rs; a1 = a; b1 = b; sel1 = sel; cin1 = cin;
    exp1_q.push_back({ec, er});
  endtask

  task automatic op8(input logic rs, input logic [W8-1:0] a, input logic [W8-1:0] b,
                     input logic sel, input logic cin, input logic [W8-1:0] er, input logic ec);
    rst8 = rs; a8 = a; b8 = b; sel8 = sel; cin8 = cin;
    exp8_q.push_back({ec, er});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    logic [1:0]  e1;
    logic [W8:0] e8;
    forever begin
      @(posedge clk);
      #1;
      if (exp1_q.size() > 0) begin
        e1 = exp1_q.pop_front();
        checks++;
        if ({cout1, r1} !== e1) begin
          errors++;
          $display("FAIL w1_result: got cout=%b r=%b, expected cout=%b r=%b",
                   cout1, r1, e1[1], e1[0]);
        end
      end
      if (exp8_q.size() > 0) begin
        e8 = exp8_q.pop_front();
        checks++;
        if ({cout8, r8} !== e8) begin
          errors++;
          $display("FAIL w8_result: got cout=%b r=%h, expected cout=%b r=%h",
                   cout8, r8, e8[W8], e8[W8-1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0; sel1 = SEL_ADD; cin1 = 1'b0;
    rst8 = 1'b1; a8 = '0;   b8 = '0;   sel8 = SEL_ADD; cin8 = 1'b0;
    tick();

    // Reset edge on both slices
    op1(1, 0, 0, SEL_ADD, 0, 0, 0);           op8(1, 8'h00, 8'h00, SEL_ADD, 0, 8'h00, 0); tick();
    // Adds (1-bit) alongside wrap / plain add and subtracts (8-bit)
    op1(0, 0, 0, SEL_ADD, 0, 0, 0);           op8(0, 8'hFF, 8'h01, SEL_ADD, 0, 8'h00, 1); tick();
    op1(0, 0, 1, SEL_ADD, 0, 1, 0);           op8(0, 8'h12, 8'h34, SEL_ADD, 0, 8'h46, 0); tick();
    op1(0, 1, 1, SEL_ADD, 0, 0, 1);           op8(0, 8'h05, 8'h07, SEL_SUB, 1, 8'hFE, 0); tick();
    // 1-bit subtracts; 8-bit reset with operands held, then release
    op1(0, 0, 1, SEL_SUB, 1, 1, 0);           op8(0, 8'h07, 8'h05, SEL_SUB, 1, 8'h02, 1); tick();
    op1(0, 1, 0, SEL_SUB, 1, 1, 1);           op8(1, 8'h12, 8'h34, SEL_ADD, 0, 8'h00, 0); tick();
    op1(0, 1, 1, SEL_SUB, 1, 0, 1);           op8(0, 8'h12, 8'h34, SEL_ADD, 0, 8'h46, 0); tick();
    // 1-bit reset with operands held; 8-bit a-b-1 (sel=1, cin=0)
    op1(1, 1, 1, SEL_ADD, 0, 0, 0);           op8(0, 8'h05, 8'h03, SEL_SUB, 0, 8'h01, 1); tick();
    op1(0, 1, 1, SEL_ADD, 0, 0, 1);           op8(0, 8'h80, 8'h80, SEL_ADD, 1, 8'h01, 1); tick();
    op1(0, 1, 0, SEL_ADD, 1, 0, 1);           op8(0, 8'h00, 8'h00, SEL_SUB, 1, 8'h00, 1); tick();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && (exp1_q.size() > 0 || exp8_q.size() > 0); i++) tick();
    if (exp1_q.size() > 0 || exp8_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", exp1_q.size(), exp8_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_process_unit
